// File: rtl/bit_stream_serializer.sv
// bit_stream_serializer
//   Turns parallel words into a gap-free serial bit stream for the sequence
//   detector. Words arrive over a valid/ready handshake. Each word is shifted
//   out one bit per clock on x, in MSB-first or LSB-first order. A word that is
//   offered during the last bit of the current word is loaded on that same edge,
//   so patterns that straddle word boundaries reach the detector intact.
//
// Handshake: a word transfers on a posedge where din_valid and din_ready are
//   both high. din_ready is combinational and depends only on rst and on
//   registered state. It never depends on din_valid. The producer must hold din
//   stable while din_valid is high and din_ready is low. din is sampled only on
//   the transfer edge.
//
// Parameters
//   WIDTH       bits per word (>= 2)
//   MSB_FIRST   1: din[WIDTH-1] leaves first, 0: din[0] leaves first
//   IDLE_LEVEL  level driven on x while nothing is shifting
//
// Ports
//   clk        clock; all state updates on posedge
//   rst        synchronous active-high reset; drops any word in flight
//   din        parallel word
//   din_valid  producer has a word on din
//   din_ready  block can take a word this cycle
//   x          serial data bit (registered)
//   x_valid    x carries a data bit this cycle (registered)
//   busy       FSM is in SHIFT; this is the full two-state FSM state
//   word_done  one-cycle pulse in the cycle after a word's last bit
module bit_stream_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             x_n, x_valid_n, word_done_n;

  logic             last_bit;
  logic             accept;
  logic             load_first, next_bit;
  logic [WIDTH-1:0] load_rest, shift_rest;

  // x already holds the current bit, so shreg keeps only the bits still to
  // go. They are aligned so the next bit is always at the outgoing end.
  always_comb begin
    if (MSB_FIRST) begin
      load_first = din[WIDTH-1];
      load_rest  = din << 1;
      next_bit   = shreg[WIDTH-1];
      shift_rest = shreg << 1;
    end else begin
      load_first = din[0];
      load_rest  = din >> 1;
      next_bit   = shreg[0];
      shift_rest = shreg >> 1;
    end
  end

  assign last_bit  = (state == SHIFT) && (bit_cnt == LAST_CNT);
  assign din_ready = !rst && ((state == IDLE) || last_bit);
  assign accept    = din_valid && din_ready;
  assign busy      = (state == SHIFT);

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    x_n         = x;
    x_valid_n   = x_valid;
    word_done_n = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          shreg_n   = load_rest;
          x_n       = load_first;
          x_valid_n = 1'b1;
          bit_cnt_n = '0;
          state_n   = SHIFT;
        end else begin
          x_n       = IDLE_LEVEL;
          x_valid_n = 1'b0;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          x_n       = next_bit;
          shreg_n   = shift_rest;
          bit_cnt_n = bit_cnt + 1'b1;
        end else begin
          word_done_n = 1'b1;
          bit_cnt_n   = '0;
          if (accept) begin
            // Back-to-back word: its first bit follows the last bit directly.
            shreg_n   = load_rest;
            x_n       = load_first;
            x_valid_n = 1'b1;
          end else begin
            x_n       = IDLE_LEVEL;
            x_valid_n = 1'b0;
            state_n   = IDLE;
          end
        end
      end
      default: begin
        state_n   = IDLE;
        bit_cnt_n = '0;
        x_n       = IDLE_LEVEL;
        x_valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      x         <= IDLE_LEVEL;
      x_valid   <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      x         <= x_n;
      x_valid   <= x_valid_n;
      word_done <= word_done_n;
    end
  end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// tb_bit_stream_serializer
//   Drives two serializer instances from one clock and reset:
//     u_dut8 : WIDTH=8, LSB first, idle level 1
//     u_dut3 : WIDTH=3, MSB first, idle level 0
//   The reference model treats each instance as a queue of pending bits in
//   emission order. An accepted word fills the queue. Each clock shows the
//   next bit. The block is ready when the queue is empty, so the bit on x is
//   the last of its word or nothing is shifting.
module tb_bit_stream_serializer;

  localparam int W0 = 8;
  localparam int W1 = 3;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic [W0-1:0] din8;
  logic          v8;
  logic          rdy8, x8, xv8, busy8, wd8;
  logic [W1-1:0] din3;
  logic          v3;
  logic          rdy3, x3, xv3, busy3, wd3;

  always #5 clk = ~clk;

  bit_stream_serializer #(.WIDTH(W0), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_dut8 (
    .clk(clk), .rst(rst), .din(din8), .din_valid(v8), .din_ready(rdy8),
    .x(x8), .x_valid(xv8), .busy(busy8), .word_done(wd8)
  );

  bit_stream_serializer #(.WIDTH(W1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut3 (
    .clk(clk), .rst(rst), .din(din3), .din_valid(v3), .din_ready(rdy3),
    .x(x3), .x_valid(xv3), .busy(busy3), .word_done(wd3)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;

  // index 0 -> u_dut8, index 1 -> u_dut3
  int          mod_w   [2] = '{W0, W1};
  bit          mod_msb [2] = '{1'b0, 1'b1};
  logic        mod_idle[2] = '{1'b1, 1'b0};
  int          pend_n  [2] = '{0, 0};
  logic [15:0] pend_bits[2];
  logic        last_shown[2] = '{1'b0, 1'b0};
  logic        ex_x [2];
  logic        ex_xv[2];
  logic        ex_wd[2];
  int          acc_n[2] = '{0, 0};

  task automatic check_eq(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] emit_order(input logic [15:0] w, input int n, input bit msb);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = msb ? w[n-1-i] : w[i];
    return r;
  endfunction

  // Advance one instance's model by one clock edge.
  task automatic model_edge(input int k, input logic r, input logic acc, input logic [15:0] word);
    if (r) begin
      pend_n[k]     = 0;
      last_shown[k] = 1'b0;
      ex_x[k]       = mod_idle[k];
      ex_xv[k]      = 1'b0;
      ex_wd[k]      = 1'b0;
    end else begin
      ex_wd[k] = last_shown[k];
      if (acc) begin
        pend_bits[k] = emit_order(word, mod_w[k], mod_msb[k]);
        pend_n[k]    = mod_w[k];
        acc_n[k]++;
      end
      if (pend_n[k] > 0) begin
        ex_x[k]       = pend_bits[k][0];
        pend_bits[k]  = pend_bits[k] >> 1;
        pend_n[k]--;
        ex_xv[k]      = 1'b1;
        last_shown[k] = (pend_n[k] == 0);
      end else begin
        ex_x[k]       = mod_idle[k];
        ex_xv[k]      = 1'b0;
        last_shown[k] = 1'b0;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a posedge. Drives inputs, checks ready before the next
  // edge, then checks registered outputs just after that edge.
  task automatic step(input logic r, input logic va, input logic [W0-1:0] da,
                      input logic vb, input logic [W1-1:0] db);
    logic ra, rb;
    rst  = r;
    v8   = va;
    din8 = da;
    v3   = vb;
    din3 = db;
    #1;
    ra = !r && (pend_n[0] == 0);
    rb = !r && (pend_n[1] == 0);
    check_eq("rdy8", rdy8, ra);
    check_eq("rdy3", rdy3, rb);
    @(posedge clk);
    #1;
    model_edge(0, r, va && ra, {8'h00, da});
    model_edge(1, r, vb && rb, {13'h0, db});
    check_eq("x8", x8, ex_x[0]);
    check_eq("xv8", xv8, ex_xv[0]);
    check_eq("busy8", busy8, ex_xv[0]);
    check_eq("wd8", wd8, ex_wd[0]);
    check_eq("x3", x3, ex_x[1]);
    check_eq("xv3", xv3, ex_xv[1]);
    check_eq("busy3", busy3, ex_xv[1]);
    check_eq("wd3", wd3, ex_wd[1]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset, with valid high to show that reset wins.
    step(1'b1, 1'b1, 8'hFF, 1'b1, 3'b111);
    step(1'b1, 1'b0, 8'h00, 1'b0, 3'b000);

    // Idle hold.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 3'b000);

    // Single words: 8'hA5 LSB first, 3'b011 MSB first.
    step(1'b0, 1'b1, 8'hA5, 1'b1, 3'b011);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 3'b000);

    // Back-to-back words with valid held until two words are taken each.
    begin
      int base8, base3;
      base8 = acc_n[0];
      base3 = acc_n[1];
      for (int i = 0; i < 24; i++)
        step(1'b0,
             (acc_n[0] - base8) < 2, (acc_n[0] == base8) ? 8'hC3 : 8'h5A,
             (acc_n[1] - base3) < 2, (acc_n[1] == base3) ? 3'b011 : 3'b110);
    end

    // Reset during bit 2 of 8'hFF.
    step(1'b0, 1'b1, 8'hFF, 1'b1, 3'b101);
    step(1'b0, 1'b0, 8'h00, 1'b0, 3'b000);
    step(1'b0, 1'b0, 8'h00, 1'b0, 3'b000);
    step(1'b1, 1'b0, 8'h00, 1'b0, 3'b000);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 3'b000);

    // Producer offers a new word mid-word, while din_ready is low.
    step(1'b0, 1'b1, 8'h3C, 1'b0, 3'b000);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'h96, 1'b0, 3'b000);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 3'b000);

    // Random traffic with din changing every cycle and occasional reset.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
           $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 3'b000);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
